// File: rtl/battleship_pkg.sv
// Constants and types shared by the cursor controller and the placement/attack states.
// Coordinate helpers wrap modulo BOARD_SIZE using COORD_W-bit arithmetic.
package battleship_pkg;

  localparam int BOARD_SIZE = 5;
  localparam int COORD_W    = 3;

  // Bit positions of the five buttons inside the packed button vectors.
  localparam int NUM_BTN     = 5;
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_CONFIRM = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [1:0] {
    CUR_IDLE,
    CUR_HOLD_WAIT,
    CUR_REPEAT
  } cursor_fsm_e;

  function automatic coord_t coord_inc(input coord_t c);
    return (c == coord_t'(BOARD_SIZE - 1)) ? '0 : c + coord_t'(1);
  endfunction

  function automatic coord_t coord_dec(input coord_t c);
    return (c == '0) ? coord_t'(BOARD_SIZE - 1) : c - coord_t'(1);
  endfunction

endpackage

// File: rtl/board_cursor_controller_if.sv
// Board-side bundle: raw buttons and enable towards the controller, cursor and strobes back.
// master = board/button side, slave = cursor controller.
interface board_cursor_controller_if;
  import battleship_pkg::*;

  logic   enable;
  logic   btn_up;
  logic   btn_down;
  logic   btn_left;
  logic   btn_right;
  logic   btn_confirm;
  coord_t i_actual;
  coord_t j_actual;
  logic   confirm_colocation_button;
  logic   cursor_moved;

  modport master (
    output enable, btn_up, btn_down, btn_left, btn_right, btn_confirm,
    input  i_actual, j_actual, confirm_colocation_button, cursor_moved
  );

  modport slave (
    input  enable, btn_up, btn_down, btn_left, btn_right, btn_confirm,
    output i_actual, j_actual, confirm_colocation_button, cursor_moved
  );

endinterface

// File: rtl/button_debouncer.sv
// One raw push-button: 2-FF synchroniser, run-length debouncer and rising-edge detector.
// The level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef logic [CNT_W-1:0] cnt_t;

  logic sync1_q;
  logic sync2_q;
  logic level_q;
  logic prev_q;
  cnt_t cnt_q;

  // NOTE: every register here uses <= so all flops sample pre-edge values; a blocking
  // assignment would collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      prev_q  <= level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == cnt_t'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + cnt_t'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/board_cursor_controller.sv
// Cursor controller: debounced buttons drive a wrapping 5x5 cursor with hold-to-repeat
// and a one-cycle confirm strobe; all outputs are registered.
module board_cursor_controller
  import battleship_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic                     clk,
  input  logic                     rst,
  board_cursor_controller_if.slave bus
);

  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  typedef logic [TMR_W-1:0] timer_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_raw[BTN_UP]      = bus.btn_up;
  assign btn_raw[BTN_DOWN]    = bus.btn_down;
  assign btn_raw[BTN_LEFT]    = bus.btn_left;
  assign btn_raw[BTN_RIGHT]   = bus.btn_right;
  assign btn_raw[BTN_CONFIRM] = bus.btn_confirm;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk      (clk),
      .rst      (rst),
      .btn_raw_i(btn_raw[g]),
      .level_o  (btn_level[g]),
      .rise_o   (btn_rise[g])
    );
  end

  cursor_fsm_e        state_q;
  dir_e               latched_q;
  timer_t             timer_q;
  coord_t             i_q;
  coord_t             j_q;
  logic               confirm_q;
  logic               moved_q;

  dir_e               press_dir;
  dir_e               move_dir;
  logic [NUM_BTN-1:0] latched_mask;
  logic               latched_held;
  timer_t             timer_limit;
  logic               timer_done;

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    press_dir    = DIR_NONE;
    latched_mask = '0;
    move_dir     = DIR_NONE;

    if (btn_rise[BTN_UP])         press_dir = DIR_UP;
    else if (btn_rise[BTN_DOWN])  press_dir = DIR_DOWN;
    else if (btn_rise[BTN_LEFT])  press_dir = DIR_LEFT;
    else if (btn_rise[BTN_RIGHT]) press_dir = DIR_RIGHT;

    case (latched_q)
      DIR_UP:    latched_mask[BTN_UP]    = 1'b1;
      DIR_DOWN:  latched_mask[BTN_DOWN]  = 1'b1;
      DIR_LEFT:  latched_mask[BTN_LEFT]  = 1'b1;
      DIR_RIGHT: latched_mask[BTN_RIGHT] = 1'b1;
      default:   latched_mask            = '0;
    endcase
    latched_held = |(btn_level & latched_mask);

    timer_limit = (state_q == CUR_REPEAT) ? timer_t'(REPEAT_CYCLES - 1)
                                          : timer_t'(HOLD_CYCLES - 1);
    timer_done  = (timer_q == timer_limit);

    // A fresh press always wins over a pending auto-repeat of the latched direction.
    if (press_dir != DIR_NONE) begin
      move_dir = press_dir;
    end else if (state_q != CUR_IDLE && latched_held && timer_done) begin
      move_dir = latched_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CUR_IDLE;
      latched_q <= DIR_NONE;
      timer_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      confirm_q <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      confirm_q <= bus.enable & btn_rise[BTN_CONFIRM];
      moved_q   <= 1'b0;

      // Confirm in the same cycle swallows the move; the FSM still tracks the press.
      if (bus.enable && !btn_rise[BTN_CONFIRM] && move_dir != DIR_NONE) begin
        moved_q <= 1'b1;
        case (move_dir)
          DIR_UP:    i_q <= coord_dec(i_q);
          DIR_DOWN:  i_q <= coord_inc(i_q);
          DIR_LEFT:  j_q <= coord_dec(j_q);
          DIR_RIGHT: j_q <= coord_inc(j_q);
          default:   moved_q <= 1'b0;
        endcase
      end

      if (!bus.enable) begin
        state_q   <= CUR_IDLE;
        latched_q <= DIR_NONE;
        timer_q   <= '0;
      end else if (press_dir != DIR_NONE) begin
        state_q   <= CUR_HOLD_WAIT;
        latched_q <= press_dir;
        timer_q   <= '0;
      end else begin
        case (state_q)
          CUR_HOLD_WAIT, CUR_REPEAT: begin
            if (!latched_held) begin
              state_q   <= CUR_IDLE;
              latched_q <= DIR_NONE;
              timer_q   <= '0;
            end else if (timer_done) begin
              state_q <= CUR_REPEAT;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + timer_t'(1);
            end
          end
          default: begin
            state_q <= CUR_IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.i_actual                  = i_q;
  assign bus.j_actual                  = j_q;
  assign bus.confirm_colocation_button = confirm_q;
  assign bus.cursor_moved              = moved_q;

endmodule

// File: tb/tb_board_cursor_controller.sv
// Bench for board_cursor_controller: directed scenarios plus random button traffic,
// all compared against a cycle-level behavioural model of the button/cursor rules.
module tb_board_cursor_controller;
  import battleship_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int HIST = 16;

  localparam bit [4:0] M_UP      = 5'b00001;
  localparam bit [4:0] M_DOWN    = 5'b00010;
  localparam bit [4:0] M_LEFT    = 5'b00100;
  localparam bit [4:0] M_RIGHT   = 5'b01000;
  localparam bit [4:0] M_CONFIRM = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_cursor_controller_if bus ();

  board_cursor_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model: raw sample history per button, debounced levels, cursor.
  bit samp   [5][HIST];
  bit m_lvl  [5];
  bit m_prev [5];
  int m_i, m_j;
  bit m_conf, m_moved;
  int m_latched = -1;
  bit m_rep;
  int m_last;
  int edge_n;

  int moved_cnt, conf_cnt;

  function automatic void model_edge(input bit r, input bit en, input bit [4:0] b);
    bit rise [5];
    int p;
    int mv;
    bit flip;
    edge_n++;
    m_conf  = 0;
    m_moved = 0;
    if (r) begin
      foreach (samp[k, a]) samp[k][a] = 0;
      foreach (m_lvl[k]) begin m_lvl[k] = 0; m_prev[k] = 0; end
      m_i = 0; m_j = 0; m_latched = -1; m_rep = 0;
      return;
    end
    foreach (rise[k]) rise[k] = m_lvl[k] & !m_prev[k];
    mv = -1;
    p  = -1;
    if (en) begin
      for (int k = 0; k < 4; k++) if (rise[k] && p < 0) p = k;
      if (p >= 0) begin
        m_latched = p; m_rep = 0; m_last = edge_n; mv = p;
      end else if (m_latched >= 0) begin
        if (!m_lvl[m_latched]) m_latched = -1;
        else if (edge_n - m_last == (m_rep ? REP : HOLD)) begin
          mv = m_latched; m_rep = 1; m_last = edge_n;
        end
      end
      if (rise[4]) m_conf = 1;
      else if (mv >= 0) begin
        m_moved = 1;
        case (mv)
          0: m_i = (m_i + BOARD_SIZE - 1) % BOARD_SIZE;
          1: m_i = (m_i + 1) % BOARD_SIZE;
          2: m_j = (m_j + BOARD_SIZE - 1) % BOARD_SIZE;
          default: m_j = (m_j + 1) % BOARD_SIZE;
        endcase
      end
    end else begin
      m_latched = -1;
    end
    // A level flips once the last DEB synchronised samples all disagree with it.
    for (int k = 0; k < 5; k++) begin
      m_prev[k] = m_lvl[k];
      flip = 1;
      for (int a = 1; a <= DEB; a++) if (samp[k][a] == m_lvl[k]) flip = 0;
      if (flip) m_lvl[k] = !m_lvl[k];
      for (int a = HIST - 1; a > 0; a--) samp[k][a] = samp[k][a-1];
      samp[k][0] = b[k];
    end
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.i_actual, bus.j_actual, bus.confirm_colocation_button, bus.cursor_moved};
  endfunction

  function automatic logic [7:0] model_vec();
    return {3'(m_i), 3'(m_j), m_conf, m_moved};
  endfunction

  task automatic tick(input bit r, input bit en, input bit [4:0] b);
    @(negedge clk);
    rst             = r;
    bus.enable      = en;
    bus.btn_up      = b[0];
    bus.btn_down    = b[1];
    bus.btn_left    = b[2];
    bus.btn_right   = b[3];
    bus.btn_confirm = b[4];
    @(posedge clk);
    model_edge(r, en, b);
    #1;
    if (bus.cursor_moved === 1'b1) moved_cnt++;
    if (bus.confirm_colocation_button === 1'b1) conf_cnt++;
  endtask

  task automatic test_reset();
    tick(1, 1, 5'h1f);
    tick(1, 1, 5'h1f);
    tests_run++;
    if (dut_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected 00", dut_vec());
    end
    for (int e = 1; e <= 6; e++) begin
      tick(0, 1, 5'h1f);
      tests_run++;
      if ({bus.confirm_colocation_button, bus.cursor_moved} !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_no_strobe edge %0d: got %b expected 00", e,
                 {bus.confirm_colocation_button, bus.cursor_moved});
      end
    end
    for (int e = 7; e <= 24; e++) begin
      tick(0, 1, (e <= 8) ? 5'h1f : 5'h00);
      tests_run++;
      if (dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL reset_drain edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    tick(1, 1, 5'h00);
    tick(1, 1, 5'h00);
    tests_run++;
    if (dut_vec() !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_again: got %h expected 00", dut_vec());
    end
  endtask

  task automatic test_clean_press();
    moved_cnt = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(0, 1, (e <= 8) ? M_RIGHT : 5'h00);
      tests_run++;
      if (bus.cursor_moved !== (e == 7) || dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL clean_press edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    tests_run++;
    if (bus.j_actual !== 3'd1 || bus.i_actual !== 3'd0 || moved_cnt != 1) begin
      tests_failed++;
      $display("FAIL clean_press_final: got i=%0d j=%0d moves=%0d expected i=0 j=1 moves=1",
               bus.i_actual, bus.j_actual, moved_cnt);
    end
  endtask

  task automatic test_glitch();
    moved_cnt = 0;
    conf_cnt  = 0;
    for (int e = 1; e <= 15; e++) begin
      tick(0, 1, (e <= 3) ? M_UP : 5'h00);
      tests_run++;
      if (dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL glitch edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    tests_run++;
    if (bus.i_actual !== 3'd0 || bus.j_actual !== 3'd1 || moved_cnt != 0 || conf_cnt != 0) begin
      tests_failed++;
      $display("FAIL glitch_final: got i=%0d j=%0d strobes=%0d expected i=0 j=1 strobes=0",
               bus.i_actual, bus.j_actual, moved_cnt + conf_cnt);
    end
  endtask

  task automatic press(input bit en, input bit [4:0] b, input int hi, input int lo);
    for (int e = 0; e < hi + lo; e++) tick(0, en, (e < hi) ? b : 5'h00);
  endtask

  task automatic test_wrap();
    moved_cnt = 0;
    press(1, M_UP, 8, 10);
    tests_run++;
    if (bus.i_actual !== 3'd4 || dut_vec() !== model_vec()) begin
      tests_failed++;
      $display("FAIL wrap_up: got i=%0d expected 4", bus.i_actual);
    end
    for (int n = 0; n < 3; n++) press(1, M_RIGHT, 8, 10);
    tests_run++;
    if (bus.j_actual !== 3'd4 || dut_vec() !== model_vec()) begin
      tests_failed++;
      $display("FAIL wrap_right_to_4: got j=%0d expected 4", bus.j_actual);
    end
    press(1, M_RIGHT, 8, 10);
    tests_run++;
    if (bus.j_actual !== 3'd0 || dut_vec() !== model_vec()) begin
      tests_failed++;
      $display("FAIL wrap_right: got j=%0d expected 0", bus.j_actual);
    end
    press(1, M_DOWN, 8, 10);
    tests_run++;
    if (bus.i_actual !== 3'd0 || moved_cnt != 6) begin
      tests_failed++;
      $display("FAIL wrap_down: got i=%0d moves=%0d expected i=0 moves=6", bus.i_actual, moved_cnt);
    end
  endtask

  task automatic test_hold();
    int got [$];
    int exp_edges [5] = '{7, 15, 19, 23, 27};
    for (int e = 1; e <= 40; e++) begin
      tick(0, 1, (e <= 24) ? M_DOWN : 5'h00);
      if (bus.cursor_moved === 1'b1) got.push_back(e);
      tests_run++;
      if (dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL hold edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    tests_run++;
    if (got.size() != 5) begin
      tests_failed++;
      $display("FAIL hold_count: got %0d pulses expected 5", got.size());
    end else begin
      foreach (exp_edges[k]) begin
        tests_run++;
        if (got[k] != exp_edges[k]) begin
          tests_failed++;
          $display("FAIL hold_edge_%0d: got edge %0d expected %0d", k, got[k], exp_edges[k]);
        end
      end
    end
    tests_run++;
    if (bus.i_actual !== 3'd0) begin
      tests_failed++;
      $display("FAIL hold_final: got i=%0d expected 0", bus.i_actual);
    end
  endtask

  task automatic test_conflict_enable();
    moved_cnt = 0;
    conf_cnt  = 0;
    press(1, M_CONFIRM | M_RIGHT, 8, 10);
    tests_run++;
    if (conf_cnt != 1 || moved_cnt != 0 || bus.j_actual !== 3'd0 || dut_vec() !== model_vec()) begin
      tests_failed++;
      $display("FAIL conflict: got confirms=%0d moves=%0d j=%0d expected 1 0 0",
               conf_cnt, moved_cnt, bus.j_actual);
    end
    moved_cnt = 0;
    conf_cnt  = 0;
    for (int e = 1; e <= 34; e++) begin
      tick(0, e > 12, (e <= 24) ? M_LEFT : 5'h00);
      tests_run++;
      if (dut_vec() !== model_vec()) begin
        tests_failed++;
        $display("FAIL enable edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    tests_run++;
    if (moved_cnt != 0 || conf_cnt != 0 || bus.i_actual !== 3'd0 || bus.j_actual !== 3'd0) begin
      tests_failed++;
      $display("FAIL enable_final: got moves=%0d i=%0d j=%0d expected 0 0 0",
               moved_cnt, bus.i_actual, bus.j_actual);
    end
  endtask

  task automatic test_random();
    bit [4:0] b;
    bit en;
    bit r;
    int len;
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 7))
        0:       b = 5'h00;
        1:       b = M_UP;
        2:       b = M_DOWN;
        3:       b = M_LEFT;
        4:       b = M_RIGHT;
        5:       b = M_CONFIRM;
        default: b = 5'($urandom_range(0, 31));
      endcase
      len = $urandom_range(1, 26);
      en  = ($urandom_range(0, 9) != 0);
      for (int e = 0; e < len; e++) begin
        r = ($urandom_range(0, 199) == 0);
        tick(r, en, b);
        tests_run++;
        if (dut_vec() !== model_vec()) begin
          tests_failed++;
          $display("FAIL random seg %0d cyc %0d: got %h expected %h", s, e, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.btn_up      = 1'b0;
    bus.btn_down    = 1'b0;
    bus.btn_left    = 1'b0;
    bus.btn_right   = 1'b0;
    bus.btn_confirm = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_wrap();
    test_hold();
    test_conflict_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
